sha3_absorb_sched: RTL
======================

Name: sha3_absorb_sched

Overview:
- Sequencing controller for the SHA3-256 Keccak datapath used by the hash stage.
- Accepts a stream of 64-bit message lanes over a valid/ready handshake and drives the datapath's lane-XOR strobes.
- Computes and issues SHA3 padding (0x06 … 0x80), runs 24-round permutations per rate block, then streams the four 64-bit digest lanes out.
- Pure control: it produces lane indices, strobes and round indices only; the datapath holds the 1600-bit state.

Parameters:
RATE_LANES, 17, lanes per rate block (136 bytes for SHA3-256)
ROUNDS, 24, Keccak-f rounds per permutation
OUT_LANES, 4, digest lanes squeezed (256 bits)

Ports:
ex_clk  in  1  clock, all state updates on rising edge
ovr_rst_n  in  1  asynchronous active-low reset
start  in  1  begin new hash; honoured only in IDLE
in_valid  in  1  message lane present
in_last  in  1  qualifies in_valid; final lane of message
in_bytes  in  4  valid bytes in the last lane, 0..8; ignored unless in_last
in_ready  out  1  controller accepts lane this cycle
busy  out  1  high in every state except IDLE
state_clr  out  1  datapath zeroes the state
xor_en  out  1  datapath XORs the input lane at lane_idx
lane_idx  out  5  current lane within the rate block, 0..RATE_LANES-1
pad_en  out  1  datapath XORs 0x06 at pad_pos and 0x80 at byte 135
pad_pos  out  8  byte offset of the 0x06 pad byte, 0..135
rnd_en  out  1  datapath applies one round
rnd_idx  out  5  round constant index, 0..ROUNDS-1
out_valid  out  1  digest lane valid
out_lane  out  2  digest lane index, 0..3
out_ready  in  1  sink accepts digest lane
done  out  1  one-cycle pulse after the last digest lane is accepted

Behaviour:
- Reset (ovr_rst_n=0, asynchronous):
  - State goes to IDLE; all counters and flags are cleared.
  - Every output is 0. This holds mid-operation as well; no partial digest is emitted afterwards.
- IDLE: start=1 -> CLEAR.
- CLEAR: one cycle with state_clr=1, lane_idx=0 -> ABSORB.
- ABSORB: in_ready=1. A lane is accepted when in_valid & in_ready.
  - Not last: xor_en=1 in the accept cycle.
    - lane_idx < RATE_LANES-1: lane_idx increments.
    - Otherwise: lane_idx wraps to 0 -> PERMUTE (final=0).
  - Last: xor_en = (in_bytes != 0). Then p = lane_idx*8 + in_bytes.
    - p <= 135: pad_pos <= p -> PAD.
    - p == 136 (full lane 16): set pad_pending, pad_pos <= 0 -> PERMUTE (final=0).
  - in_bytes > 8 is illegal: treated as 8, and error behaviour is not required.
- PAD: one cycle with pad_en=1, then set final=1 -> PERMUTE.
  - pad_pos == 135 is legal; the datapath merges 0x06 and 0x80 into 0x86.
- PERMUTE: rnd_en=1 for exactly ROUNDS consecutive cycles, rnd_idx counting 0..ROUNDS-1; in_ready=0 throughout. After the cycle with rnd_idx = ROUNDS-1:
  - final=1 -> SQUEEZE, out_lane=0.
  - else pad_pending=1 -> clear pad_pending, lane_idx=0 -> PAD.
  - else -> ABSORB, lane_idx=0.
- SQUEEZE: out_valid=1 with out_lane held until out_ready.
  - On out_valid & out_ready with out_lane < 3: out_lane increments.
  - With out_lane = 3 -> DONE.
  - out_valid may not drop without acceptance.
- DONE: done=1 for one cycle, final cleared -> IDLE.
- start outside IDLE is ignored; in_valid outside ABSORB is ignored (in_ready=0).
- Strobes xor_en, pad_en, rnd_en, state_clr are mutually exclusive in every cycle.
- Latency, empty message (start at cycle 0, lane offered immediately):
  - CLEAR at 1, accept at 2, PAD at 3, rounds at 4..27.
  - First out_valid at 28; done one cycle after the 4th accept.
- Latency per full rate block: 17 accept cycles + 24 round cycles.

Test Plan:
- Empty message: start; one lane with in_last=1, in_bytes=0 -> xor_en=0, pad_en at pad_pos=0, 24 rnd_en cycles with rnd_idx 0..23, 4 out_valid lanes, one done pulse.
- 3-byte message in lane 0 -> xor_en=1 at lane_idx=0, pad_pos=3, single permutation, done.
- 17 full lanes with the last flagged at in_bytes=8 -> permutation, PAD with pad_pos=0 at lane_idx=0, second permutation, squeeze; exactly 48 rnd_en cycles total.
- 16 full lanes plus lane 16 with in_bytes=7 -> pad_pos=135, one permutation only.
- out_ready held low 5 cycles on lane 2 -> out_valid and out_lane=2 stable, no done until lanes 2 and 3 are accepted.
- ovr_rst_n pulsed low at rnd_idx=10 -> all outputs 0 immediately, IDLE; a new start then produces a correct full sequence. Also: start asserted during PERMUTE has no effect.

Source files
------------

// File: rtl/sha3_absorb_sched.sv
// sha3_absorb_sched: SHA3-256 sequencing controller. Absorbs 64-bit lanes, issues padding,
// runs 24-round permutations per rate block and streams four digest lanes.
module sha3_absorb_sched #(
    parameter int RATE_LANES = 17,
    parameter int ROUNDS     = 24,
    parameter int OUT_LANES  = 4
) (
    input  logic       ex_clk,
    input  logic       ovr_rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic       in_last,
    input  logic [3:0] in_bytes,
    output logic       in_ready,
    output logic       busy,
    output logic       state_clr,
    output logic       xor_en,
    output logic [4:0] lane_idx,
    output logic       pad_en,
    output logic [7:0] pad_pos,
    output logic       rnd_en,
    output logic [4:0] rnd_idx,
    output logic       out_valid,
    output logic [1:0] out_lane,
    input  logic       out_ready,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, CLEAR, ABSORB, PAD, PERMUTE, SQUEEZE, DONE} state_t;

    state_t     state, state_nx;
    logic       final_q, pad_pending;
    logic       accept, last_lane, last_rnd, last_out, pad_wrap;
    logic [3:0] nbytes;
    logic [7:0] p;

    // Oversized byte counts saturate to a full lane.
    assign nbytes    = in_bytes > 4'd8 ? 4'd8 : in_bytes;
    assign p         = {lane_idx, 3'b000} + {4'b0000, nbytes};
    assign pad_wrap  = p == 8'(RATE_LANES * 8);
    assign accept    = in_ready && in_valid;
    assign last_lane = lane_idx == 5'(RATE_LANES - 1);
    assign last_rnd  = rnd_idx == 5'(ROUNDS - 1);
    assign last_out  = out_lane == 2'(OUT_LANES - 1);

    always_comb begin
        state_nx  = state;
        busy      = state != IDLE;
        in_ready  = state == ABSORB;
        state_clr = state == CLEAR;
        pad_en    = state == PAD;
        rnd_en    = state == PERMUTE;
        out_valid = state == SQUEEZE;
        done      = state == DONE;
        xor_en    = state == ABSORB && in_valid && (!in_last || nbytes != 4'd0);
        case (state)
            IDLE:    state_nx = start ? CLEAR : IDLE;
            CLEAR:   state_nx = ABSORB;
            ABSORB:  state_nx = !in_valid ? ABSORB :
                                in_last ? (pad_wrap ? PERMUTE : PAD) :
                                last_lane ? PERMUTE : ABSORB;
            PAD:     state_nx = PERMUTE;
            PERMUTE: state_nx = !last_rnd ? PERMUTE : final_q ? SQUEEZE : pad_pending ? PAD : ABSORB;
            SQUEEZE: state_nx = out_ready && last_out ? DONE : SQUEEZE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ex_clk or negedge ovr_rst_n) begin
        if (!ovr_rst_n) begin
            state       <= IDLE;
            lane_idx    <= '0;
            pad_pos     <= '0;
            rnd_idx     <= '0;
            out_lane    <= '0;
            final_q     <= 1'b0;
            pad_pending <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                lane_idx    <= '0;
                pad_pos     <= '0;
                rnd_idx     <= '0;
                out_lane    <= '0;
                final_q     <= 1'b0;
                pad_pending <= 1'b0;
            end
            if (accept && !in_last)
                lane_idx <= last_lane ? '0 : lane_idx + 5'd1;
            // A message ending exactly on the block boundary needs a padding-only block.
            if (accept && in_last) begin
                pad_pos     <= pad_wrap ? '0 : p;
                pad_pending <= pad_wrap;
            end
            if (pad_en)
                final_q <= 1'b1;
            if (rnd_en)
                rnd_idx <= last_rnd ? '0 : rnd_idx + 5'd1;
            if (rnd_en && last_rnd) begin
                lane_idx    <= '0;
                pad_pending <= 1'b0;
            end
            if (out_valid && out_ready)
                out_lane <= last_out ? '0 : out_lane + 2'd1;
            if (done)
                final_q <= 1'b0;
        end
    end
endmodule
